riscv_ctrl_pipe: RTL and testbench



---
 rtl/riscv_ctrl_pkg.sv | 45 ++++
 rtl/riscv_ctrl_if.sv | 38 +++
 rtl/riscv_ctrl_decode.sv | 58 +++++
 rtl/riscv_ctrl_pipe.sv | 108 ++++++++++
 tb/tb_riscv_ctrl_pipe.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the RISC-V main-control decode and the ID/EX control register.
// Opcodes, ALU classes, bundle layout and instruction field extractors.
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I_ALU = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  localparam logic [1:0] ALU_MEM = 2'b00;
  localparam logic [1:0] ALU_BR  = 2'b01;
  localparam logic [1:0] ALU_R   = 2'b10;
  localparam logic [1:0] ALU_I   = 2'b11;

  // Bundle field order, MSB first.
  typedef struct packed {
    logic       alu_src;
    logic       memtoreg;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       branch;
    logic       jump;
    logic [1:0] alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00};

  function automatic logic [4:0] rd_of(input logic [31:0] inst);
    return inst[11:7];
  endfunction

  function automatic logic [4:0] rs1_of(input logic [31:0] inst);
    return inst[19:15];
  endfunction

  function automatic logic [4:0] rs2_of(input logic [31:0] inst);
    return inst[24:20];
  endfunction

endpackage

// File: rtl/riscv_ctrl_if.sv
// Fetch-side and execute-side handshake plus the registered control bundle.
interface riscv_ctrl_if #(
  parameter int ALU_OP_W  = 2,
  parameter int RF_ADDR_W = 5,
  parameter int CNT_W     = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic [31:0]          inst;
  logic                 flush;
  logic                 out_valid;
  logic                 out_ready;
  logic                 alu_src;
  logic                 memtoreg;
  logic                 regwrite;
  logic                 memread;
  logic                 memwrite;
  logic                 branch;
  logic                 jump;
  logic [ALU_OP_W-1:0]  alu_op;
  logic [RF_ADDR_W-1:0] rd;
  logic [RF_ADDR_W-1:0] rs1;
  logic [RF_ADDR_W-1:0] rs2;
  logic                 illegal;
  logic [CNT_W-1:0]     bubble_cnt;

  modport master (
    output in_valid, inst, flush, out_ready,
    input  in_ready, out_valid, alu_src, memtoreg, regwrite, memread, memwrite,
           branch, jump, alu_op, rd, rs1, rs2, illegal, bubble_cnt
  );

  modport slave (
    input  in_valid, inst, flush, out_ready,
    output in_ready, out_valid, alu_src, memtoreg, regwrite, memread, memwrite,
           branch, jump, alu_op, rd, rs1, rs2, illegal, bubble_cnt
  );
endinterface

// File: rtl/riscv_ctrl_decode.sv
// Combinational main-control decoder: opcode to control bundle, source usage and illegal flag.
module riscv_ctrl_decode
  import riscv_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output ctrl_t      ctrl,
  output logic       uses_rs1,
  output logic       uses_rs2,
  output logic       illegal
);

  // Opcode table; unsupported opcodes decode to an all-zero bundle.
  always_comb begin
    ctrl     = CTRL_NONE;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    illegal  = 1'b0;
    case (opcode)
      OP_R: begin
        ctrl     = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ALU_R};
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OP_I_ALU: begin
        ctrl     = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ALU_I};
        uses_rs1 = 1'b1;
      end
      OP_LOAD: begin
        ctrl     = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, ALU_MEM};
        uses_rs1 = 1'b1;
      end
      OP_STORE: begin
        ctrl     = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, ALU_MEM};
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OP_BR: begin
        ctrl     = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ALU_BR};
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OP_JAL: begin
        ctrl     = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, ALU_MEM};
      end
      OP_JALR: begin
        ctrl     = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, ALU_MEM};
        uses_rs1 = 1'b1;
      end
      OP_LUI: begin
        ctrl     = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ALU_MEM};
      end
      default: begin
        illegal  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/riscv_ctrl_pipe.sv
// ID/EX control register: decodes the incoming instruction, holds the bundle with register
// addresses, inserts a one-cycle bubble on load-use and counts those bubbles.
module riscv_ctrl_pipe
  import riscv_ctrl_pkg::*;
#(
  parameter int ALU_OP_W  = 2,
  parameter int RF_ADDR_W = 5,
  parameter int HAZARD_EN = 1,
  parameter int CNT_W     = 16
) (
  input logic         clk,
  input logic         rst,
  riscv_ctrl_if.slave bus
);

  localparam logic HAZ_ON = (HAZARD_EN != 0);

  ctrl_t                dec_ctrl_s;
  logic                 dec_rs1_s;
  logic                 dec_rs2_s;
  logic                 dec_illegal_s;
  logic                 hazard_s;
  logic                 in_ready_s;
  logic                 accept_s;
  logic                 drain_s;
  logic [ALU_OP_W-1:0]  alu_op_s;
  logic                 unused_inst_s;

  logic                 out_valid_r;
  ctrl_t                ctrl_r;
  logic                 illegal_r;
  logic [RF_ADDR_W-1:0] rd_r;
  logic [RF_ADDR_W-1:0] rs1_r;
  logic [RF_ADDR_W-1:0] rs2_r;
  logic [CNT_W-1:0]     bubble_cnt_r;

  riscv_ctrl_decode u_decode (
    .opcode   (bus.inst[6:0]),
    .ctrl     (dec_ctrl_s),
    .uses_rs1 (dec_rs1_s),
    .uses_rs2 (dec_rs2_s),
    .illegal  (dec_illegal_s)
  );

  // Funct fields are decoded downstream in execute.
  assign unused_inst_s = ^{bus.inst[31:25], bus.inst[14:12]};

  // Load-use detect against the held entry and the input-side handshake.
  always_comb begin
    hazard_s = HAZ_ON & out_valid_r & ctrl_r.memread & (rd_r != '0) & bus.in_valid &
               ((dec_rs1_s & (rs1_of(bus.inst) == rd_r)) |
                (dec_rs2_s & (rs2_of(bus.inst) == rd_r)));
    in_ready_s = ~bus.flush & ~hazard_s & (~out_valid_r | bus.out_ready);
    accept_s   = bus.in_valid & in_ready_s;
    drain_s    = bus.out_ready & out_valid_r;
  end

  // Pipeline register; drain and flush clear it so an invalid slot always reads zero.
  always_ff @(posedge clk) begin
    if (rst || bus.flush || (drain_s && !accept_s)) begin
      out_valid_r <= 1'b0;
      ctrl_r      <= CTRL_NONE;
      illegal_r   <= 1'b0;
      rd_r        <= '0;
      rs1_r       <= '0;
      rs2_r       <= '0;
    end else if (accept_s) begin
      out_valid_r <= 1'b1;
      ctrl_r      <= dec_ctrl_s;
      illegal_r   <= dec_illegal_s;
      rd_r        <= rd_of(bus.inst);
      rs1_r       <= rs1_of(bus.inst);
      rs2_r       <= rs2_of(bus.inst);
    end
  end

  // Bubble counter: a hazard cycle with out_ready set is the drain that becomes the bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt_r <= '0;
    end else if (hazard_s && bus.out_ready && !bus.flush && (bubble_cnt_r != '1)) begin
      bubble_cnt_r <= bubble_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // ALU class sits in the low two bits of a possibly wider port.
  always_comb begin
    alu_op_s      = '0;
    alu_op_s[1:0] = ctrl_r.alu_op;
  end

  assign bus.in_ready   = in_ready_s;
  assign bus.out_valid  = out_valid_r;
  assign bus.alu_src    = ctrl_r.alu_src;
  assign bus.memtoreg   = ctrl_r.memtoreg;
  assign bus.regwrite   = ctrl_r.regwrite;
  assign bus.memread    = ctrl_r.memread;
  assign bus.memwrite   = ctrl_r.memwrite;
  assign bus.branch     = ctrl_r.branch;
  assign bus.jump       = ctrl_r.jump;
  assign bus.alu_op     = alu_op_s;
  assign bus.rd         = rd_r;
  assign bus.rs1        = rs1_r;
  assign bus.rs2        = rs2_r;
  assign bus.illegal    = illegal_r;
  assign bus.bubble_cnt = bubble_cnt_r;

endmodule

// File: tb/tb_riscv_ctrl_pipe.sv
// Directed bench for riscv_ctrl_pipe with a scoreboard of expected bundles (CNT_W=2 for saturation).
module tb_riscv_ctrl_pipe;

  localparam logic [31:0] I_ADD   = 32'h002081B3;
  localparam logic [31:0] I_LW5   = 32'h0000A283;
  localparam logic [31:0] I_ADD65 = 32'h00228333;
  localparam logic [31:0] I_LW0   = 32'h0000A003;
  localparam logic [31:0] I_ADD60 = 32'h00200333;
  localparam logic [31:0] I_ILL   = 32'h0000007F;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_miss;
  logic exp_ov;
  logic [24:0] sb[$];

  riscv_ctrl_if #(.ALU_OP_W(2), .RF_ADDR_W(5), .CNT_W(2)) bus ();

  riscv_ctrl_pipe #(.ALU_OP_W(2), .RF_ADDR_W(5), .HAZARD_EN(1), .CNT_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference table: {alu_src,memtoreg,regwrite,memread,memwrite,branch,jump,alu_op[1:0],illegal}
  function automatic logic [9:0] ref_ctrl(input logic [6:0] op);
    case (op)
      7'b0110011: return 10'b0_0_1_0_0_0_0_10_0;
      7'b0010011: return 10'b1_0_1_0_0_0_0_11_0;
      7'b0000011: return 10'b1_1_1_1_0_0_0_00_0;
      7'b0100011: return 10'b1_0_0_0_1_0_0_00_0;
      7'b1100011: return 10'b0_0_0_0_0_1_0_01_0;
      7'b1101111: return 10'b0_0_1_0_0_0_1_00_0;
      7'b1100111: return 10'b1_0_1_0_0_0_1_00_0;
      7'b0110111: return 10'b1_0_1_0_0_0_0_00_0;
      default:    return 10'b0_0_0_0_0_0_0_00_1;
    endcase
  endfunction

  function automatic logic [24:0] ref_bundle(input logic [31:0] i);
    return {ref_ctrl(i[6:0]), i[11:7], i[19:15], i[24:20]};
  endfunction

  function automatic logic [24:0] dut_bundle();
    return {bus.alu_src, bus.memtoreg, bus.regwrite, bus.memread, bus.memwrite,
            bus.branch, bus.jump, bus.alu_op, bus.illegal, bus.rd, bus.rs1, bus.rs2};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One cycle: drive at negedge, check settled outputs, update scoreboard, advance.
  task automatic step(input string tag, input logic v, input logic [31:0] i,
                      input logic fl, input logic rdy, input logic exp_rdy);
    logic acc;
    logic nxt;
    bus.in_valid  = v;
    bus.inst      = i;
    bus.flush     = fl;
    bus.out_ready = rdy;
    #1;
    chk({tag, "/in_ready"}, {31'd0, bus.in_ready}, {31'd0, exp_rdy});
    chk({tag, "/out_valid"}, {31'd0, bus.out_valid}, {31'd0, exp_ov});
    if (exp_ov) begin
      if (sb.size() == 0) chk({tag, "/sb_empty"}, 32'd1, 32'd0);
      else chk({tag, "/bundle"}, {7'd0, dut_bundle()}, {7'd0, sb[0]});
    end else begin
      chk({tag, "/idle_zero"}, {7'd0, dut_bundle()}, 32'd0);
    end
    acc = v & exp_rdy;
    if (fl) begin
      sb.delete();
      nxt = 1'b0;
    end else begin
      if (exp_ov && rdy && sb.size() > 0) void'(sb.pop_front());
      if (acc) sb.push_back(ref_bundle(i));
      nxt = acc ? 1'b1 : ((exp_ov & rdy) ? 1'b0 : exp_ov);
    end
    @(posedge clk);
    exp_ov = nxt;
    @(negedge clk);
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
    exp_ov = 1'b0;
    rst    = 1'b1;
    bus.in_valid  = 1'b0;
    bus.inst      = 32'd0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset/out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("reset/bundle", {7'd0, dut_bundle()}, 32'd0);
    chk("reset/bubble_cnt", {30'd0, bus.bubble_cnt}, 32'd0);
    rst = 1'b0;

    step("stream0", 1'b1, I_ADD, 1'b0, 1'b1, 1'b1);
    step("stream1", 1'b0, 32'd0, 1'b0, 1'b1, 1'b1);

    step("lu0", 1'b1, I_LW5,   1'b0, 1'b1, 1'b1);
    step("lu1", 1'b1, I_ADD65, 1'b0, 1'b1, 1'b0);
    step("lu2", 1'b1, I_ADD65, 1'b0, 1'b1, 1'b1);
    step("lu3", 1'b0, 32'd0,   1'b0, 1'b1, 1'b1);
    chk("lu/bubble_cnt", {30'd0, bus.bubble_cnt}, 32'd1);

    step("x0_0", 1'b1, I_LW0,   1'b0, 1'b1, 1'b1);
    step("x0_1", 1'b1, I_ADD60, 1'b0, 1'b1, 1'b1);
    step("x0_2", 1'b0, 32'd0,   1'b0, 1'b1, 1'b1);
    chk("x0/bubble_cnt", {30'd0, bus.bubble_cnt}, 32'd1);

    step("bp0", 1'b1, I_ADD, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) step("bp_stall", 1'b1, I_ADD65, 1'b0, 1'b0, 1'b0);
    step("bp_drain", 1'b0, 32'd0, 1'b0, 1'b1, 1'b1);

    step("fl_in", 1'b1, I_ADD, 1'b1, 1'b1, 1'b0);
    step("fl_chk", 1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
    step("fl_hold", 1'b1, I_ADD, 1'b0, 1'b0, 1'b1);
    step("fl_held", 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    step("fl_gone", 1'b0, 32'd0, 1'b0, 1'b1, 1'b1);

    step("ill0", 1'b1, I_ILL, 1'b0, 1'b1, 1'b1);
    step("ill1", 1'b0, 32'd0, 1'b0, 1'b1, 1'b1);

    for (int k = 0; k < 5; k++) begin
      step("sat0", 1'b1, I_LW5,   1'b0, 1'b1, 1'b1);
      step("sat1", 1'b1, I_ADD65, 1'b0, 1'b1, 1'b0);
      step("sat2", 1'b1, I_ADD65, 1'b0, 1'b1, 1'b1);
      step("sat3", 1'b0, 32'd0,   1'b0, 1'b1, 1'b1);
      chk($sformatf("sat%0d/bubble_cnt", k), {30'd0, bus.bubble_cnt},
          (k + 2 > 3) ? 32'd3 : 32'(k + 2));
    end

    step("rst_hold", 1'b1, I_ADD, 1'b0, 1'b0, 1'b1);
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    sb.delete();
    exp_ov = 1'b0;
    chk("rst_mid/out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_mid/bubble_cnt", {30'd0, bus.bubble_cnt}, 32'd0);
    chk("rst_mid/bundle", {7'd0, dut_bundle()}, 32'd0);
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
